// File: rtl/hs_fifo_bridge_if.sv
// Handshake bundle for hs_fifo_bridge: upstream req/ack intake, downstream req/ack delivery and status.
// The master modport is the bridge itself; the slave modport is the surrounding harness.
interface hs_fifo_bridge_if #(
   parameter int DATA_W = 32
);
   logic              up_req;
   logic              up_ack;
   logic [DATA_W-1:0] up_din;
   logic              dn_req;
   logic              dn_ack;
   logic [DATA_W-1:0] dn_dout;
   logic [31:0]       occupancy;
   logic              overflow;

   modport master (
      output up_req, dn_ack, dn_dout, occupancy, overflow,
      input  up_ack, up_din, dn_req
   );

   modport slave (
      input  up_req, dn_ack, dn_dout, occupancy, overflow,
      output up_ack, up_din, dn_req
   );
endinterface

// File: rtl/hs_fifo_bridge.sv
// Elastic req/ack FIFO: requests words from an upstream responder and answers downstream
// requests with one-cycle acks, tracking occupancy and a sticky overflow flag.
module hs_fifo_bridge #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   hs_fifo_bridge_if.master bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [31:0]      OCC_FULL = 32'(DEPTH);

   localparam logic [0:0] UP_IDLE = 1'b0;
   localparam logic [0:0] UP_REQ  = 1'b1;
   localparam logic [0:0] DN_WAIT = 1'b0;
   localparam logic [0:0] DN_ACK  = 1'b1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0]       occ_q, occ_d;
   logic [0:0]        up_state_q, up_state_d;
   logic [0:0]        dn_state_q, dn_state_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              ovf_q, ovf_d;
   logic              full, empty, push, pop;

   // Pointers wrap explicitly so any DEPTH (not only powers of two) works.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   always_comb begin
      full  = (occ_q == OCC_FULL);
      empty = (occ_q == '0);
      push  = bus.up_ack & ~full;
      // A pop needs the ack line low, so acks are never back to back.
      pop   = bus.dn_req & (dn_state_q == DN_WAIT) & ~empty;

      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d      = occ_q + 32'(push) - 32'(pop);
      ovf_d      = ovf_q | (bus.up_ack & full);
      dout_d     = pop ? mem_q[rd_ptr_q] : dout_q;
      dn_state_d = pop ? DN_ACK : DN_WAIT;
      // Requesting only while the next occupancy leaves room keeps a compliant responder from overflowing.
      up_state_d = (occ_d < OCC_FULL) ? UP_REQ : UP_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         ovf_q      <= 1'b0;
         dout_q     <= '0;
         up_state_q <= UP_IDLE;
         dn_state_q <= DN_WAIT;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         ovf_q      <= ovf_d;
         dout_q     <= dout_d;
         up_state_q <= up_state_d;
         dn_state_q <= dn_state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= bus.up_din;
      end
   end

   assign bus.up_req    = (up_state_q == UP_REQ);
   assign bus.dn_ack    = (dn_state_q == DN_ACK);
   assign bus.dn_dout   = dout_q;
   assign bus.occupancy = occ_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_hs_fifo_bridge.sv
// Bench for hs_fifo_bridge: queue-based reference model, scoreboard of accepted words,
// directed scenarios followed by a randomized handshake phase.
module tb_hs_fifo_bridge;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hs_fifo_bridge_if #(.DATA_W(DATA_W)) bus ();

   hs_fifo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus knobs
   int          up_rate   = 0;
   int          up_budget = -1;
   bit          rand_data = 0;
   bit          ovf_force = 0;
   int          dn_mode   = 0;
   int          dn_rate   = 50;
   logic [31:0] data_cnt  = 0;

   initial begin
      bus.up_ack = 1'b0;
      bus.up_din = '0;
      bus.dn_req = 1'b0;
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (ovf_force) begin
         bus.up_ack = 1'b1;
         bus.up_din = 32'hDEAD;
      end else if (bus.up_req && !bus.up_ack && up_budget != 0 &&
                   ($urandom_range(99) < up_rate)) begin
         bus.up_ack = 1'b1;
         bus.up_din = rand_data ? $urandom : data_cnt;
         data_cnt++;
         if (up_budget > 0) up_budget--;
      end else begin
         bus.up_ack = 1'b0;
      end
      case (dn_mode)
         0:       bus.dn_req = 1'b0;
         1:       bus.dn_req = 1'b1;
         default: bus.dn_req = ($urandom_range(99) < dn_rate);
      endcase
   endtask

   // Reference model: contents queue plus scoreboard of every accepted word.
   logic [31:0] mdl_q[$];
   logic [31:0] sb_q[$];
   bit          m_ack = 0, m_ovf = 0, m_upreq = 0, started = 0;
   bit          m_pop, m_push;
   logic [31:0] m_dout = 0;

   always @(posedge clk) begin
      if (rst) begin
         mdl_q.delete();
         sb_q.delete();
         m_ack   = 0;
         m_ovf   = 0;
         m_upreq = 0;
         m_dout  = 0;
         started = 1;
      end else begin
         m_pop  = bus.dn_req && !m_ack && (mdl_q.size() > 0);
         m_push = bus.up_ack && (mdl_q.size() < DEPTH);
         if (bus.up_ack && !m_push) m_ovf = 1;
         if (m_pop) m_dout = mdl_q.pop_front();
         if (m_push) begin
            mdl_q.push_back(bus.up_din);
            sb_q.push_back(bus.up_din);
         end
         m_ack   = m_pop;
         m_upreq = (mdl_q.size() < DEPTH);
      end
   end

   // Monitor
   int          out_cnt = 0;
   logic [31:0] exp_word;
   always @(negedge clk) begin
      if (started) begin
         chk("up_req", bus.up_req, m_upreq);
         chk("dn_ack", bus.dn_ack, m_ack);
         chk("occupancy", bus.occupancy, mdl_q.size());
         chk("overflow", bus.overflow, m_ovf);
         if (bus.dn_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dn_ack_no_word: got dn_dout=%0h expected no ack at %0t", bus.dn_dout, $time);
            end else begin
               exp_word = sb_q.pop_front();
               chk("dn_dout_order", bus.dn_dout, exp_word);
               out_cnt++;
            end
         end else begin
            chk("dn_dout_hold", bus.dn_dout, m_dout);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   int          base, maxocc;
   logic [31:0] t4_first, t6_first;
   bit          t6_seen;

   initial begin
      // Reset held for two edges
      rst = 1'b1;
      step();
      step();
      chk("t1_up_req", bus.up_req, 0);
      chk("t1_dn_ack", bus.dn_ack, 0);
      chk("t1_occupancy", bus.occupancy, 0);
      chk("t1_overflow", bus.overflow, 0);
      rst = 1'b0;
      step();
      chk("t1_up_req_after", bus.up_req, 1);

      // Streaming 0..9
      data_cnt = 0; rand_data = 0; up_rate = 100; up_budget = 10; dn_mode = 1;
      base = out_cnt; maxocc = 0;
      for (int i = 0; i < 200 && (out_cnt - base) < 10; i++) begin
         step();
         if (int'(bus.occupancy) > maxocc) maxocc = int'(bus.occupancy);
      end
      chk("t2_words", out_cnt - base, 10);
      chk("t2_occ_le_2", (maxocc <= 2), 1);

      // Fill and drain
      dn_mode = 0; up_budget = -1; up_rate = 100;
      for (int i = 0; i < 50 && bus.occupancy != DEPTH; i++) step();
      step(); step(); step();
      chk("t3_full", bus.occupancy, DEPTH);
      chk("t3_up_req_low", bus.up_req, 0);
      up_rate = 0; dn_mode = 1; base = out_cnt;
      step();
      step();
      chk("t3_up_req_back", bus.up_req, 1);
      for (int i = 0; i < 50 && bus.occupancy != 0; i++) step();
      step();
      chk("t3_drained", out_cnt - base, DEPTH);

      // Simultaneous push and pop at occupancy 2
      dn_mode = 0; up_rate = 100; up_budget = 2; t4_first = data_cnt;
      for (int i = 0; i < 50 && bus.occupancy != 2; i++) step();
      step();
      chk("t4_occ_before", bus.occupancy, 2);
      up_budget = 1; dn_mode = 1;
      step();
      step();
      chk("t4_occ_same", bus.occupancy, 2);
      chk("t4_ack", bus.dn_ack, 1);
      chk("t4_oldest", bus.dn_dout, t4_first);
      dn_mode = 0; up_rate = 0;
      step(); step();

      // Overflow by a non-compliant ack
      up_rate = 100; up_budget = -1;
      for (int i = 0; i < 50 && bus.occupancy != DEPTH; i++) step();
      up_rate = 0;
      step();
      ovf_force = 1;
      step();
      ovf_force = 0;
      step();
      chk("t5_overflow", bus.overflow, 1);
      chk("t5_occ", bus.occupancy, DEPTH);
      dn_mode = 1;
      for (int i = 0; i < 50 && bus.occupancy != 0; i++) step();
      step();
      chk("t5_drained", bus.occupancy, 0);
      chk("t5_overflow_sticky", bus.overflow, 1);

      // Reset mid-operation
      dn_mode = 0; up_rate = 100; up_budget = 3;
      for (int i = 0; i < 50 && bus.occupancy != 3; i++) step();
      chk("t6_occ3", bus.occupancy, 3);
      up_budget = -1;
      rst = 1'b1;
      step();
      chk("t6_occ_reset", bus.occupancy, 0);
      chk("t6_ack_reset", bus.dn_ack, 0);
      chk("t6_ovf_reset", bus.overflow, 0);
      rst = 1'b0; up_rate = 0;
      step();
      t6_first = data_cnt; up_rate = 100; up_budget = 1; dn_mode = 1; t6_seen = 0;
      for (int i = 0; i < 50 && !t6_seen; i++) begin
         step();
         if (bus.dn_ack === 1'b1) begin
            t6_seen = 1;
            chk("t6_first_out", bus.dn_dout, t6_first);
         end
      end
      chk("t6_output_seen", t6_seen, 1);

      // Randomized handshakes with occasional resets
      rand_data = 1; up_budget = -1; dn_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            up_rate = $urandom_range(100, 20);
            dn_rate = $urandom_range(100, 10);
         end
         rst = ($urandom_range(499) == 0);
         step();
      end
      rst = 1'b0; up_rate = 0; dn_mode = 1;
      for (int i = 0; i < 30; i++) step();
      chk("final_occ", bus.occupancy, 0);
      chk("final_sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
